// File: rtl/blkmem_fifo_ctrl.sv
// blkmem_fifo_ctrl
//   16-entry FIFO controller in front of a single-port, synchronous-read
//   BlkMem (1-cycle read latency). Owns the pointers, occupancy and the
//   output register; the memory only stores the data words.
//
// Ports
//   clk, rst_n            system clock / async active-low reset
//   enq, din, enq_ack     push side (enq_ack combinational)
//   deq, deq_ack          pop side (deq_ack combinational, pop has priority)
//   dout, dout_valid      popped word, registered; dout_valid pulses once
//                         two cycles after deq_ack, dout holds until next pop
//   full, empty, count    occupancy flags, derived from registered count
//   mem_en/we/addr/din    drive BlkMem ena/wea/addra/dina
//   mem_dout              BlkMem douta
module blkmem_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq,
  input  logic [DATA_W-1:0] din,
  output logic              enq_ack,
  input  logic              deq,
  output logic              deq_ack,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              rd_pending;

  assign count = cnt;
  assign full  = (cnt == DEPTH);
  assign empty = (cnt == '0);

  // One memory port: a pop wins over a push so the read pipeline never
  // stalls; the pusher simply holds enq and retries.
  assign deq_ack = deq & ~empty;
  assign enq_ack = enq & ~full & ~deq_ack;

  assign mem_en   = enq_ack | deq_ack;
  assign mem_we   = enq_ack;
  assign mem_addr = enq_ack ? wr_ptr : rd_ptr;
  assign mem_din  = din;

  // Pointers wrap naturally at 2**ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_ack) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        cnt    <= cnt + CNT_ONE;
      end else if (deq_ack) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        cnt    <= cnt - CNT_ONE;
      end
    end
  end

  // Read pipeline: deq_ack (T) -> rd_pending (T+1, mem_dout valid)
  // -> dout/dout_valid (T+2). mem_dout is only looked at while rd_pending,
  // so write cycles disturbing douta never reach dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      rd_pending <= deq_ack;
      dout_valid <= rd_pending;
      if (rd_pending) dout <= mem_dout;
    end
  end

endmodule

// File: tb/tb_blkmem_fifo_ctrl.sv
// Bench for blkmem_fifo_ctrl: behavioural BlkMem, reference FIFO model and
// a scoreboard of expected pop results tagged with their due cycle.
module tb_blkmem_fifo_ctrl;
  logic       clk, rst_n, enq, deq;
  logic [7:0] din, dout, mem_din, mem_dout;
  logic       enq_ack, deq_ack, dout_valid, full, empty, mem_en, mem_we;
  logic [4:0] count;
  logic [3:0] mem_addr;

  blkmem_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .enq(enq), .din(din), .enq_ack(enq_ack),
    .deq(deq), .deq_ack(deq_ack), .dout(dout), .dout_valid(dout_valid),
    .full(full), .empty(empty), .count(count), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BlkMem model: 16x8, sync read, write-first so writes disturb douta.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_din;
        mem_dout      <= mem_din;
      end else begin
        mem_dout <= ram[mem_addr];
      end
    end
  end

  typedef struct { logic [7:0] data; int due; } exp_t;
  exp_t       expq [$];
  logic [7:0] mq [$];
  logic [3:0] wp, rp;
  logic [7:0] last;
  int         cyc_no, errors, checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc_no);
    end
  endtask

  // One clock cycle starting at a negedge: drive, check, update model.
  task automatic cyc(input logic e, input logic d, input logic [7:0] v);
    logic exp_v, exp_deq, exp_enq;
    exp_t x;
    enq = e; deq = d; din = v;
    #1;
    exp_v = (expq.size() > 0) && (expq[0].due == cyc_no);
    chk("dout_valid", {31'd0, dout_valid}, {31'd0, exp_v});
    if (exp_v) begin
      x = expq.pop_front();
      if (dout_valid) chk("dout_data", {24'd0, dout}, {24'd0, x.data});
      last = x.data;
    end else begin
      chk("dout_hold", {24'd0, dout}, {24'd0, last});
    end
    exp_deq = d && (mq.size() > 0);
    exp_enq = e && (mq.size() < 16) && !exp_deq;
    chk("deq_ack", {31'd0, deq_ack}, {31'd0, exp_deq});
    chk("enq_ack", {31'd0, enq_ack}, {31'd0, exp_enq});
    chk("count",   {27'd0, count},   32'(mq.size()));
    chk("full",    {31'd0, full},    {31'd0, mq.size() == 16});
    chk("empty",   {31'd0, empty},   {31'd0, mq.size() == 0});
    chk("mem_en",  {31'd0, mem_en},  {31'd0, exp_enq | exp_deq});
    chk("mem_we",  {31'd0, mem_we},  {31'd0, exp_enq});
    chk("mem_addr",{28'd0, mem_addr},{28'd0, exp_enq ? wp : rp});
    if (exp_enq) chk("mem_din", {24'd0, mem_din}, {24'd0, v});
    if (exp_enq) begin
      mq.push_back(v);
      wp = 4'(wp + 4'd1);
    end
    if (exp_deq) begin
      x.data = mq.pop_front();
      x.due  = cyc_no + 2;
      expq.push_back(x);
      rp = 4'(rp + 4'd1);
    end
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, {27'd0, count}, 32'd0);
    chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
    chk({tag, "_full"},  {31'd0, full},  32'd0);
    chk({tag, "_dout"},  {24'd0, dout},  32'd0);
    chk({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
    chk({tag, "_mem_en"},{31'd0, mem_en}, 32'd0);
    chk({tag, "_acks"},  {30'd0, enq_ack, deq_ack}, 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0; cyc_no = 0;
    wp = '0; rp = '0; last = '0;
    rst_n = 1'b0; enq = 1'b0; deq = 1'b0; din = '0;
    @(negedge clk); #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // three pushes then three back-to-back pops
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);

    // fill to full, overflow attempt, drain
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
    cyc(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);             // pop while empty: ignored
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);

    // pointer wrap
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);

    // simultaneous enq & deq: empty, count=5, full
    cyc(1'b1, 1'b1, 8'h80);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'h81 + i));
    cyc(1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
    cyc(1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);

    // reset in the cycle after deq_ack: result must never appear
    cyc(1'b1, 1'b0, 8'h5A);
    cyc(1'b1, 1'b0, 8'h5B);
    cyc(1'b0, 1'b1, 8'h00);
    enq = 1'b0; deq = 1'b0; rst_n = 1'b0;
    #1;
    chk_reset_state("midread");
    mq.delete(); expq.delete();
    wp = '0; rp = '0; last = '0;
    @(negedge clk); cyc_no++;
    #1;
    chk_reset_state("midread_hold");
    @(negedge clk); cyc_no++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h33);
    cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/blkmem_fifo_ctrl.md
Name: blkmem_fifo_ctrl

Overview:
- 16-entry, 8-bit FIFO controller that sits directly upstream of the single-port BlkMem (16x8, synchronous read, 1-cycle read latency).
- Drives the memory's en/we/addr/din, consumes its dout, and presents a push/pop queue interface to the lab top level.
- Owns pointers, occupancy and output register; the memory holds only the data.

Parameters:
- DATA_W, 8, data width; must equal the BlkMem word width.
- ADDR_W, 4, address width; depth is 2**ADDR_W = 16 entries.

Ports:
- clk  in  1  single system clock; also drives BlkMem clka
- rst_n  in  1  asynchronous active-low reset
- enq  in  1  push request
- din  in  DATA_W  push data
- enq_ack  out  1  push accepted this cycle (combinational)
- deq  in  1  pop request
- deq_ack  out  1  pop accepted this cycle (combinational)
- dout  out  DATA_W  popped data (registered, held until next pop completes)
- dout_valid  out  1  one-cycle pulse when dout updates
- full  out  1  count == 16
- empty  out  1  count == 0
- count  out  ADDR_W+1  occupancy, 0..16
- mem_en  out  1  to BlkMem ena
- mem_we  out  1  to BlkMem wea
- mem_addr  out  ADDR_W  to BlkMem addra
- mem_din  out  DATA_W  to BlkMem dina
- mem_dout  in  DATA_W  from BlkMem douta

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, count=0, rd_pending=0, dout=0, dout_valid=0. Outputs therefore read empty=1, full=0, enq_ack=0, deq_ack=0, mem_en=0.
- Acceptance (combinational, single memory port):
  - deq_ack = deq & ~empty.
  - enq_ack = enq & ~full & ~deq_ack. Pop has priority.
  - Empty with enq & deq both high: enq accepted, deq ignored.
  - Full with enq & deq both high: deq accepted, enq rejected; requester must hold enq.
  - Neither full nor empty with both high: deq accepted, enq retried next cycle.
- Memory drive (combinational):
  - mem_en = enq_ack | deq_ack; mem_we = enq_ack.
  - mem_addr = wr_ptr on push, else rd_ptr.
  - mem_din = din.
  - Idle: mem_en=0, mem_we=0, mem_addr=rd_ptr.
- Clock edge after a push: wr_ptr <= wr_ptr+1 (mod 16); count <= count+1.
- Clock edge after a pop: rd_ptr <= rd_ptr+1 (mod 16); count <= count-1.
- Pushes and pops are never accepted in the same cycle, so count changes by at most ±1 per cycle.
- Read pipeline, 2-cycle latency:
  - T: deq_ack=1, memory samples rd_ptr.
  - T+1: rd_pending=1, mem_dout holds the word.
  - Edge ending T+1: dout <= mem_dout.
  - T+2: dout_valid=1 for exactly one cycle.
- rd_pending <= deq_ack every cycle. Back-to-back pops are allowed: one result per cycle, in order.
- mem_dout is ignored whenever rd_pending=0. Write cycles may disturb BlkMem douta without affecting dout.
- Pointer wrap: 15 -> 0 for both pointers, no bubble.
- full/empty/count are pure functions of the registered count.
- Pushes while full or pops while empty: no state change, no ack.
- Reset mid-read: pending read discarded, dout_valid stays 0, dout=0.
- Data integrity: pop order equals push order across any number of wraps.

Test Plan:
- Reset then push 0x00,0x01,0x02 on consecutive cycles -> enq_ack=1 each cycle; mem_we=1 with mem_addr=0,1,2; count=3; empty=0.
- Pop three times back-to-back -> deq_ack=1 on cycles T..T+2; dout=0x00,0x01,0x02 with dout_valid high on T+2..T+4; count=0; empty=1.
- Push 16 words 0x10..0x1F, then push 0xAA -> full=1 after 16th push, enq_ack=0 for 0xAA, count=16. Pop 16 -> 0x10..0x1F in order, 0xAA never appears.
- Wrap: push 10, pop 10, push 10 -> wr_ptr wraps 15->0 (mem_addr goes 15 then 0). Pop 10 -> data in push order.
- Simultaneous enq&deq:
  - empty -> enq_ack=1, deq_ack=0.
  - count=5 -> deq_ack=1, enq_ack=0, count=4.
  - full -> deq_ack=1, enq_ack=0, count=15.
- Assert rst_n low the cycle after deq_ack -> dout_valid never pulses; count=0, empty=1, dout=0 asynchronously while reset is low.
